// File: rtl/calc_pkg.sv
// Shared types and frame-layout helpers for the calculator
// frame receiver and other ClkTx-domain consumers.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

    localparam int SEL_W     = 4;
    localparam int FLAG_W    = 4;
    localparam int OFF_FLAGS = 0;
    localparam int OFF_SEL   = FLAG_W;
    localparam int OFF_RES   = FLAG_W + SEL_W;

    function automatic int framelen(input int inbits);
        return SEL_W + FLAG_W + 3 * inbits;
    endfunction

    function automatic int off_opb(input int inbits);
        return OFF_RES + inbits;
    endfunction

    function automatic int off_opa(input int inbits);
        return OFF_RES + 2 * inbits;
    endfunction

endpackage

// File: rtl/calc_frame_receiver_edge_detect.sv
// Registers ClkTx in the Clk domain and emits a one-cycle
// pulse on each rising edge.
module edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_q <= 1'b0;
        else          r_q <= i_sig;
    end

    assign o_rise = i_sig & ~r_q;

endmodule

// File: rtl/calc_frame_receiver.sv
// Reassembles the serial calculator result stream into a frame
// and hands it to a local consumer over a valid/ack handshake.
module calc_frame_receiver
    import calc_pkg::*;
#(
    parameter int INBITS   = 8,
    parameter int SBITI    = 4,
    parameter int FRAMELEN = framelen(INBITS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ClkTx,
    input  logic              DoutValid,
    input  logic [SBITI-1:0]  DataOut,
    input  logic              FrameAck,
    input  logic              ClearErr,
    output logic              FrameValid,
    output logic [INBITS-1:0] OpA,
    output logic [INBITS-1:0] OpB,
    output logic [INBITS-1:0] Result,
    output logic [3:0]        SelOut,
    output logic [3:0]        Flags,
    output logic              FrameErr,
    output logic              Overrun,
    output logic [7:0]        FrameCount
);

    localparam int BEATS = FRAMELEN / SBITI;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int O_OPA = off_opa(INBITS);
    localparam int O_OPB = off_opb(INBITS);

    rx_state_t r_state;
    rx_state_t w_next;

    logic                      w_rise;
    logic                      w_beat;
    logic                      w_end;
    logic                      w_at_last;
    logic                      w_load1;
    logic                      w_shift_en;
    logic                      w_complete;
    logic                      w_trunc;
    logic                      w_extra;
    logic                      w_accept;
    logic                      w_ovr_evt;
    logic [CW-1:0]             r_cnt;
    logic [FRAMELEN-SBITI-1:0] r_shift;
    logic [FRAMELEN-1:0]       w_word;

    logic              r_valid;
    logic [INBITS-1:0] r_opa;
    logic [INBITS-1:0] r_opb;
    logic [INBITS-1:0] r_res;
    logic [3:0]        r_sel;
    logic [3:0]        r_flags;
    logic              r_err;
    logic              r_ovr;
    logic [7:0]        r_count;

    edge_detect u_edge (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_sig   (ClkTx),
        .o_rise  (w_rise)
    );

    assign w_beat    = w_rise & DoutValid;
    assign w_end     = w_rise & ~DoutValid;
    assign w_at_last = (r_cnt == CW'(BEATS - 1));
    assign w_word    = {r_shift, DataOut};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_beat) w_next = SHIFT;
            end
            SHIFT: begin
                if (w_beat && w_at_last) w_next = DONE;
                else if (w_end)          w_next = IDLE;
            end
            DONE: begin
                if (w_end) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load1    = 1'b0;
        w_shift_en = 1'b0;
        w_complete = 1'b0;
        w_trunc    = 1'b0;
        w_extra    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_shift_en = w_beat;
                w_load1    = w_beat;
            end
            SHIFT: begin
                w_shift_en = w_beat;
                w_complete = w_beat & w_at_last;
                w_trunc    = w_end;
            end
            DONE: begin
                w_extra = w_beat;
            end
            default: ;
        endcase
    end

    // An ack on the completion edge frees the slot for the new frame.
    assign w_accept  = w_complete & (~r_valid | FrameAck);
    assign w_ovr_evt = w_complete & r_valid & ~FrameAck;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            if (w_shift_en) r_shift <= w_word[FRAMELEN-SBITI-1:0];
            if (w_complete || w_trunc) r_cnt <= '0;
            else if (w_load1)          r_cnt <= CW'(1);
            else if (w_shift_en)       r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_valid <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_res   <= '0;
            r_sel   <= '0;
            r_flags <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_opa   <= w_word[O_OPA +: INBITS];
                r_opb   <= w_word[O_OPB +: INBITS];
                r_res   <= w_word[OFF_RES +: INBITS];
                r_sel   <= w_word[OFF_SEL +: SEL_W];
                r_flags <= w_word[OFF_FLAGS +: FLAG_W];
                r_count <= r_count + 8'd1;
            end else if (FrameAck) begin
                r_valid <= 1'b0;
            end
        end
    end

    // A new error event on the clear edge keeps the flag set.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_err <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            r_err <= w_trunc | w_extra | (r_err & ~ClearErr);
            r_ovr <= w_ovr_evt | (r_ovr & ~ClearErr);
        end
    end

    assign FrameValid = r_valid;
    assign OpA        = r_opa;
    assign OpB        = r_opb;
    assign Result     = r_res;
    assign SelOut     = r_sel;
    assign Flags      = r_flags;
    assign FrameErr   = r_err;
    assign Overrun    = r_ovr;
    assign FrameCount = r_count;

endmodule
